// File: rtl/register_file_sb_if.sv
// ----------------------------------------------------------------------------
// register_file_sb_if
// Bus bundle between decode/writeback logic and the scoreboarded register
// file.
//
// Signals (direction seen from the master, i.e. the pipeline):
//   a1, a2   out  AW       read port addresses
//   rd1, rd2 in   WIDTH    read port data
//   b1, b2   in   1        busy flag of the register at a1 / a2
//   a3       out  AW       write address
//   we3      out  1        write enable
//   wd3      out  WIDTH    write data
//   ra       out  AW       reserve address (destination of issuing instr)
//   re       out  1        reserve enable
//   busycnt  in   AW+1     number of registers currently marked busy
// ----------------------------------------------------------------------------
interface register_file_sb_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    a1;
    logic [AW-1:0]    a2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             b1;
    logic             b2;
    logic [AW-1:0]    a3;
    logic             we3;
    logic [WIDTH-1:0] wd3;
    logic [AW-1:0]    ra;
    logic             re;
    logic [AW:0]      busycnt;

    modport master (
        output a1, a2, a3, we3, wd3, ra, re,
        input  rd1, rd2, b1, b2, busycnt
    );

    modport slave (
        input  a1, a2, a3, we3, wd3, ra, re,
        output rd1, rd2, b1, b2, busycnt
    );
endinterface

// File: rtl/register_file_sb.sv
// ----------------------------------------------------------------------------
// register_file_sb
// Two-read / one-write register file with a per-register busy scoreboard.
// Reads are combinational with optional same-cycle write-through bypass;
// register 0 can be hardwired to zero. Busy bits are set when an instruction
// reserves its destination and cleared when that register is written back,
// so decode can stall on operands that are still in flight.
//
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   rst   in   synchronous active-high reset (clears data, busy, count)
//   bus   slave modport of register_file_sb_if (read, write, reserve ports
//         and the registered busy count)
// ----------------------------------------------------------------------------
module register_file_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    register_file_sb_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      busycnt_q;
    logic [AW:0]      busycnt_d;

    // Register 0 is inert only when the zero-register option is enabled.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Next-state: the write clears busy first so a same-cycle reservation of
    // the same register wins (the reserving instruction is the new producer).
    // The count is taken from the next busy vector so it lands on the same
    // edge as the busy bits themselves.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        busycnt_d = '0;
        if (bus.we3 && !is_zero_reg(bus.a3)) begin
            regs_d[bus.a3] = bus.wd3;
            busy_d[bus.a3] = 1'b0;
        end
        if (bus.re && !is_zero_reg(bus.ra)) begin
            busy_d[bus.ra] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            busycnt_d = busycnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // State registers; reset overrides any write or reserve in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            busycnt_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            busycnt_q <= busycnt_d;
        end
    end

    // Read ports. Stored state is shown even while rst is high; only a
    // same-cycle write is forwarded, never a same-cycle reservation.
    always_comb begin
        bus.rd1 = regs_q[bus.a1];
        bus.b1  = busy_q[bus.a1];
        if (is_zero_reg(bus.a1)) begin
            bus.rd1 = '0;
            bus.b1  = 1'b0;
        end else if (BYPASS && bus.we3 && (bus.a3 == bus.a1)) begin
            bus.rd1 = bus.wd3;
            bus.b1  = 1'b0;
        end

        bus.rd2 = regs_q[bus.a2];
        bus.b2  = busy_q[bus.a2];
        if (is_zero_reg(bus.a2)) begin
            bus.rd2 = '0;
            bus.b2  = 1'b0;
        end else if (BYPASS && bus.we3 && (bus.a3 == bus.a2)) begin
            bus.rd2 = bus.wd3;
            bus.b2  = 1'b0;
        end

        bus.busycnt = busycnt_q;
    end
endmodule
